// File: rtl/vec_unit_arbiter_pkg.sv
// Shared types for the vector-unit arbiter: fixed-point vector, op codes, requester ID.
package vec_unit_arbiter_pkg;

    typedef logic signed [15:0] fixed_t;
    typedef logic [2:0][15:0]   vector_t;

    typedef enum logic [1:0] {
        VOP_ADD   = 2'd0,
        VOP_SUB   = 2'd1,
        VOP_DOT   = 2'd2,
        VOP_CROSS = 2'd3
    } vec_op_t;

    typedef logic req_id_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/vec_unit_arbiter_if.sv
// Request, issue, result and per-requester output channels of the vector-unit arbiter.
interface vec_unit_arbiter_if;
    import vec_unit_arbiter_pkg::*;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    vector_t    req_a0, req_b0, req_a1, req_b1;
    vec_op_t    req_op0, req_op1;

    logic       iss_valid;
    logic       iss_ready;
    vector_t    iss_a, iss_b;
    vec_op_t    iss_op;

    logic       res_valid;
    logic       res_ready;
    vector_t    res_data;

    logic [1:0] out_valid;
    logic [1:0] out_ready;
    vector_t    out_data;

    // master: requesters plus the arithmetic unit; slave: the arbiter
    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  req_ready,
        input  iss_valid, iss_a, iss_b, iss_op,
        output iss_ready,
        output res_valid, res_data,
        input  res_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output req_ready,
        output iss_valid, iss_a, iss_b, iss_op,
        input  iss_ready,
        input  res_valid, res_data,
        output res_ready,
        output out_valid, out_data,
        input  out_ready
    );

endinterface

// File: rtl/vec_unit_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per request outstanding in the unit.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     din_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_MAX);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A full FIFO refuses the push even when a pop frees a slot this cycle
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)
                count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push)
                count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/vec_unit_arbiter.sv
// Round-robin share of one vector unit between two requesters, with in-order result steering.
module vec_unit_arbiter
    import vec_unit_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    vec_unit_arbiter_if.slave bus,
    output logic              err
);
    localparam int AW = $clog2(TAG_DEPTH);

    logic    rr_last_q, rr_last_d;
    logic    iss_valid_q, iss_valid_d;
    vector_t iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    vec_op_t iss_op_q, iss_op_d;
    logic    err_q, err_d;

    req_id_t grant;
    logic    grant_any, accept;
    logic    tag_head, tag_empty, tag_full, res_ready_w, pop;
    logic [AW:0] unused_tag_count;

    // Contention goes to whoever was not served last; otherwise the lone requester
    always_comb begin
        grant_any = |bus.req_valid;
        if (&bus.req_valid)
            grant = ~rr_last_q;
        else
            grant = bus.req_valid[1];
    end

    assign accept = rst_n & grant_any & (~iss_valid_q | bus.iss_ready) & ~tag_full;

    always_comb begin
        bus.req_ready        = 2'b00;
        bus.req_ready[grant] = accept;
    end

    always_comb begin
        rr_last_d   = rr_last_q;
        iss_valid_d = iss_valid_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_op_d    = iss_op_q;
        err_d       = err_q | (bus.res_valid & tag_empty);
        if (accept) begin
            rr_last_d   = grant;
            iss_valid_d = 1'b1;
            iss_a_d     = grant ? bus.req_a1  : bus.req_a0;
            iss_b_d     = grant ? bus.req_b1  : bus.req_b0;
            iss_op_d    = grant ? bus.req_op1 : bus.req_op0;
        end else if (iss_valid_q && bus.iss_ready) begin
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q   <= 1'b1;
            iss_valid_q <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_op_q    <= VOP_ADD;
            err_q       <= 1'b0;
        end else begin
            rr_last_q   <= rr_last_d;
            iss_valid_q <= iss_valid_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_op_q    <= iss_op_d;
            err_q       <= err_d;
        end
    end

    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_a     = iss_a_q;
    assign bus.iss_b     = iss_b_q;
    assign bus.iss_op    = iss_op_q;
    assign err           = err_q;

    // Results come back in issue order, so the FIFO head names the owner
    always_comb begin
        bus.out_valid           = 2'b00;
        bus.out_valid[tag_head] = bus.res_valid & ~tag_empty;
    end

    assign res_ready_w   = bus.out_ready[tag_head] & ~tag_empty;
    assign bus.res_ready = res_ready_w;
    assign bus.out_data  = bus.res_data;
    assign pop           = bus.res_valid & res_ready_w;

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .din_i   (grant),
        .pop_i   (pop),
        .head_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full),
        .count_o (unused_tag_count)
    );

endmodule

// File: tb/tb_vec_unit_arbiter.sv
// Bench for vec_unit_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_vec_unit_arbiter;
    import vec_unit_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;

    vec_unit_arbiter_if vif();

    vec_unit_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: last winner, issue slot contents, queue of outstanding owners
    int      m_rr_last = 1;
    bit      m_iss_v   = 0;
    vector_t m_iss_a   = '0;
    vector_t m_iss_b   = '0;
    vec_op_t m_iss_op  = VOP_ADD;
    bit      m_err     = 0;
    int      m_tags[$];

    function automatic vector_t mkv(int x, int y, int z);
        vector_t v;
        v[0] = 16'(x);
        v[1] = 16'(y);
        v[2] = 16'(z);
        return v;
    endfunction

    function automatic vector_t rndv();
        vector_t v;
        for (int k = 0; k < 3; k++) v[k] = 16'($urandom);
        return v;
    endfunction

    function automatic int m_grant();
        if (vif.req_valid == 2'b11) return 1 - m_rr_last;
        if (vif.req_valid[0]) return 0;
        if (vif.req_valid[1]) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] m_req_ready();
        int g;
        g = m_grant();
        if (!rst_n || g < 0) return 2'b00;
        if (m_iss_v && !vif.iss_ready) return 2'b00;
        if (m_tags.size() >= DEPTH) return 2'b00;
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] m_out_valid();
        if (m_tags.size() == 0 || !vif.res_valid) return 2'b00;
        return (m_tags[0] == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic m_res_ready();
        if (m_tags.size() == 0) return 1'b0;
        return vif.out_ready[m_tags[0]];
    endfunction

    // Advance the model with the inputs held this cycle, then move to the next falling edge
    task automatic cyc();
        logic [1:0] rr;
        int g;
        bit pop, empty;
        rr    = m_req_ready();
        g     = m_grant();
        empty = (m_tags.size() == 0);
        pop   = vif.res_valid && m_res_ready();
        if (!rst_n) begin
            m_rr_last = 1; m_iss_v = 0; m_iss_a = '0; m_iss_b = '0;
            m_iss_op = VOP_ADD; m_err = 0; m_tags.delete();
        end else begin
            if (vif.res_valid && empty) m_err = 1;
            if (pop) void'(m_tags.pop_front());
            if (rr != 2'b00) begin
                m_iss_a  = (g == 1) ? vif.req_a1  : vif.req_a0;
                m_iss_b  = (g == 1) ? vif.req_b1  : vif.req_b0;
                m_iss_op = (g == 1) ? vif.req_op1 : vif.req_op0;
                m_tags.push_back(g);
                m_rr_last = g;
                m_iss_v   = 1;
            end else if (m_iss_v && vif.iss_ready) begin
                m_iss_v = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        vif.req_valid = 2'b00;
        vif.req_a0 = '0; vif.req_b0 = '0; vif.req_a1 = '0; vif.req_b1 = '0;
        vif.req_op0 = VOP_ADD; vif.req_op1 = VOP_ADD;
        vif.iss_ready = 1'b0;
        vif.res_valid = 1'b0;
        vif.res_data  = '0;
        vif.out_ready = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vif.req_valid = 2'b11;
        #1;
        n_checks++; if (vif.req_ready !== 2'b00) $display("FAIL rst_req_ready got %b want 00", vif.req_ready); else n_pass++;
        cyc();
        cyc();
        n_checks++; if (vif.iss_valid !== 1'b0) $display("FAIL rst_iss_valid got %b want 0", vif.iss_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
        n_checks++; if (vif.iss_a !== '0) $display("FAIL rst_iss_a got %h want 0", vif.iss_a); else n_pass++;
        vif.res_valid = 1'b1;
        vif.out_ready = 2'b11;
        #1;
        n_checks++; if (vif.out_valid !== 2'b00) $display("FAIL rst_out_valid got %b want 00", vif.out_valid); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b0) $display("FAIL rst_res_ready got %b want 0", vif.res_ready); else n_pass++;
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        vif.req_valid = 2'b01;
        vif.req_a0 = mkv(1, 2, 3);
        vif.req_b0 = mkv(3, 2, 1);
        vif.req_op0 = VOP_ADD;
        vif.iss_ready = 1'b1;
        #1;
        n_checks++; if (vif.req_ready !== 2'b01) $display("FAIL single_req_ready got %b want 01", vif.req_ready); else n_pass++;
        cyc();
        vif.req_valid = 2'b00;
        n_checks++; if (vif.iss_valid !== 1'b1) $display("FAIL single_iss_valid got %b want 1", vif.iss_valid); else n_pass++;
        n_checks++; if (vif.iss_a !== mkv(1, 2, 3)) $display("FAIL single_iss_a got %h want %h", vif.iss_a, mkv(1, 2, 3)); else n_pass++;
        n_checks++; if (vif.iss_op !== VOP_ADD) $display("FAIL single_iss_op got %0d want %0d", vif.iss_op, VOP_ADD); else n_pass++;
        vif.res_valid = 1'b1;
        vif.res_data  = mkv(4, 4, 4);
        vif.out_ready = 2'b01;
        #1;
        n_checks++; if (vif.out_valid !== 2'b01) $display("FAIL single_out_valid got %b want 01", vif.out_valid); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b1) $display("FAIL single_res_ready got %b want 1", vif.res_ready); else n_pass++;
        n_checks++; if (vif.out_data !== mkv(4, 4, 4)) $display("FAIL single_out_data got %h want %h", vif.out_data, mkv(4, 4, 4)); else n_pass++;
        cyc();
        idle();
        n_checks++; if (vif.iss_valid !== 1'b0) $display("FAIL single_iss_drop got %b want 0", vif.iss_valid); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        vif.req_valid = 2'b11;
        vif.req_a0 = mkv(10, 0, 0);  vif.req_op0 = VOP_ADD;
        vif.req_a1 = mkv(20, 0, 0);  vif.req_op1 = VOP_SUB;
        vif.iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            n_checks++; if (vif.req_ready !== exp) $display("FAIL cont_grant%0d got %b want %b", i, vif.req_ready, exp); else n_pass++;
            cyc();
            n_checks++; if (vif.iss_op !== ((i % 2 == 1) ? VOP_SUB : VOP_ADD)) $display("FAIL cont_iss_op%0d got %0d", i, vif.iss_op); else n_pass++;
        end
        vif.req_valid = 2'b00;
        vif.out_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1) ? 2'b10 : 2'b01;
            vif.res_valid = 1'b1;
            vif.res_data  = mkv(i, i, i);
            #1;
            n_checks++; if (vif.out_valid !== exp) $display("FAIL cont_route%0d got %b want %b", i, vif.out_valid, exp); else n_pass++;
            cyc();
        end
        idle();
    endtask

    task automatic test_issue_stall();
        do_reset();
        vif.req_valid = 2'b01;
        vif.req_a0 = mkv(7, 8, 9);
        vif.req_op0 = VOP_DOT;
        vif.iss_ready = 1'b1;
        cyc();
        vif.iss_ready = 1'b0;
        vif.req_valid = 2'b11;
        vif.req_a0 = mkv(1, 1, 1);
        vif.req_a1 = mkv(2, 2, 2);
        vif.req_op1 = VOP_CROSS;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (vif.req_ready !== 2'b00) $display("FAIL stall_req_ready%0d got %b want 00", i, vif.req_ready); else n_pass++;
            cyc();
            n_checks++; if (vif.iss_a !== mkv(7, 8, 9) || vif.iss_op !== VOP_DOT || vif.iss_valid !== 1'b1)
                $display("FAIL stall_hold%0d got v=%b a=%h op=%0d want v=1 a=%h op=%0d", i, vif.iss_valid, vif.iss_a, vif.iss_op, mkv(7, 8, 9), VOP_DOT);
            else n_pass++;
        end
        vif.req_valid = 2'b00;
        vif.iss_ready = 1'b1;
        cyc();
        vif.iss_ready = 1'b0;
        n_checks++; if (vif.iss_valid !== 1'b0) $display("FAIL stall_drop got %b want 0", vif.iss_valid); else n_pass++;
        idle();
    endtask

    task automatic test_fifo_full();
        do_reset();
        vif.req_valid = 2'b01;
        vif.iss_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vif.req_a0 = mkv(i, 0, 0);
            #1;
            n_checks++; if (vif.req_ready !== 2'b01) $display("FAIL full_fill%0d got %b want 01", i, vif.req_ready); else n_pass++;
            cyc();
        end
        #1;
        n_checks++; if (vif.req_ready !== 2'b00) $display("FAIL full_block got %b want 00", vif.req_ready); else n_pass++;
        vif.res_valid = 1'b1;
        vif.out_ready = 2'b11;
        #1;
        n_checks++; if (vif.req_ready !== 2'b00) $display("FAIL full_block_on_pop got %b want 00", vif.req_ready); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b1) $display("FAIL full_res_ready got %b want 1", vif.res_ready); else n_pass++;
        cyc();
        vif.res_valid = 1'b0;
        #1;
        n_checks++; if (vif.req_ready !== 2'b01) $display("FAIL full_one_more got %b want 01", vif.req_ready); else n_pass++;
        cyc();
        #1;
        n_checks++; if (vif.req_ready !== 2'b00) $display("FAIL full_again got %b want 00", vif.req_ready); else n_pass++;
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        vif.req_valid = 2'b10;
        vif.req_a1 = mkv(3, 3, 3);
        vif.iss_ready = 1'b1;
        cyc();
        vif.req_valid = 2'b00;
        vif.res_valid = 1'b1;
        vif.res_data  = mkv(9, 9, 9);
        vif.out_ready = 2'b01;
        #1;
        n_checks++; if (vif.out_valid !== 2'b10) $display("FAIL bp_out_valid got %b want 10", vif.out_valid); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b0) $display("FAIL bp_res_ready got %b want 0", vif.res_ready); else n_pass++;
        cyc();
        vif.out_ready = 2'b10;
        #1;
        n_checks++; if (vif.out_valid !== 2'b10) $display("FAIL bp_held got %b want 10", vif.out_valid); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b1) $display("FAIL bp_release got %b want 1", vif.res_ready); else n_pass++;
        cyc();
        vif.res_valid = 1'b0;
        vif.out_ready = 2'b11;
        #1;
        n_checks++; if (vif.res_ready !== 1'b0) $display("FAIL bp_popped got %b want 0", vif.res_ready); else n_pass++;
        idle();
    endtask

    task automatic test_error_reset();
        do_reset();
        vif.res_valid = 1'b1;
        vif.out_ready = 2'b11;
        #1;
        n_checks++; if (vif.out_valid !== 2'b00) $display("FAIL err_out_valid got %b want 00", vif.out_valid); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b0) $display("FAIL err_res_ready got %b want 0", vif.res_ready); else n_pass++;
        cyc();
        vif.res_valid = 1'b0;
        n_checks++; if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else n_pass++;
        cyc();
        n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else n_pass++;
        vif.req_valid = 2'b01;
        vif.iss_ready = 1'b1;
        cyc();
        cyc();
        vif.req_valid = 2'b00;
        vif.res_valid = 1'b1;
        vif.out_ready = 2'b01;
        #1;
        n_checks++; if (vif.out_valid !== 2'b01) $display("FAIL err_two_tags got %b want 01", vif.out_valid); else n_pass++;
        vif.res_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_checks++; if (err !== 1'b0) $display("FAIL err_cleared got %b want 0", err); else n_pass++;
        vif.res_valid = 1'b1;
        vif.out_ready = 2'b11;
        #1;
        n_checks++; if (vif.out_valid !== 2'b00) $display("FAIL err_flushed_valid got %b want 00", vif.out_valid); else n_pass++;
        n_checks++; if (vif.res_ready !== 1'b0) $display("FAIL err_flushed_ready got %b want 0", vif.res_ready); else n_pass++;
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            vif.req_valid = 2'($urandom_range(0, 3));
            vif.req_a0 = rndv(); vif.req_b0 = rndv();
            vif.req_a1 = rndv(); vif.req_b1 = rndv();
            vif.req_op0 = vec_op_t'($urandom_range(0, 3));
            vif.req_op1 = vec_op_t'($urandom_range(0, 3));
            vif.iss_ready = ($urandom_range(0, 3) != 0);
            if (m_tags.size() > 0) vif.res_valid = 1'($urandom_range(0, 1));
            else                   vif.res_valid = ($urandom_range(0, 31) == 0);
            vif.res_data  = rndv();
            vif.out_ready = 2'($urandom_range(0, 3));
            #1;
            n_checks++; if (vif.req_ready !== m_req_ready()) $display("FAIL rnd_req_ready@%0d got %b want %b", i, vif.req_ready, m_req_ready()); else n_pass++;
            n_checks++; if (vif.out_valid !== m_out_valid()) $display("FAIL rnd_out_valid@%0d got %b want %b", i, vif.out_valid, m_out_valid()); else n_pass++;
            n_checks++; if (vif.res_ready !== m_res_ready()) $display("FAIL rnd_res_ready@%0d got %b want %b", i, vif.res_ready, m_res_ready()); else n_pass++;
            n_checks++; if (vif.out_data !== vif.res_data) $display("FAIL rnd_out_data@%0d got %h want %h", i, vif.out_data, vif.res_data); else n_pass++;
            cyc();
            n_checks++; if (vif.iss_valid !== m_iss_v) $display("FAIL rnd_iss_valid@%0d got %b want %b", i, vif.iss_valid, m_iss_v); else n_pass++;
            n_checks++; if (vif.iss_a !== m_iss_a || vif.iss_b !== m_iss_b || vif.iss_op !== m_iss_op)
                $display("FAIL rnd_iss_payload@%0d got %h/%h/%0d want %h/%h/%0d", i, vif.iss_a, vif.iss_b, vif.iss_op, m_iss_a, m_iss_b, m_iss_op);
            else n_pass++;
            n_checks++; if (err !== m_err) $display("FAIL rnd_err@%0d got %b want %b", i, err, m_err); else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_issue_stall();
        test_fifo_full();
        test_backpressure();
        test_error_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_unit_arbiter.md
# vec_unit_arbiter

Shares one vector arithmetic unit between two requesters in the coprocessor datapath. Requests are granted round-robin, registered into a single issue slot, and each issued request's requester ID is recorded in an in-order tag FIFO. Results returning from the unit are steered to the originating requester's result port, performing the vector demultiplex with full valid/ready backpressure.

## Interface
Parameters:
- TAG_DEPTH, 4: maximum number of requests outstanding inside the unit; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid[1:0]  in  2  request valid, one bit per requester.
- req_ready[1:0]  out  2  request accepted when valid and ready are both high.
- req_a0, req_b0, req_a1, req_b1  in  vector  operands for requesters 0 and 1.
- req_op0, req_op1  in  vec_op_t  operation code for requesters 0 and 1.
- iss_valid  out  1  issue slot holds a request for the unit.
- iss_ready  in  1  the unit accepts the issue.
- iss_a, iss_b  out  vector  issued operands.
- iss_op  out  vec_op_t  issued operation.
- res_valid  in  1  unit result valid; results return in issue order.
- res_ready  out  1  result consumed.
- res_data  in  vector  unit result.
- out_valid[1:0]  out  2  result valid per requester.
- out_ready[1:0]  in  2  requester accepts its result.
- out_data  out  vector  result data, shared by both output ports.
- err  out  1  sticky: a result arrived while the tag FIFO was empty.

## Operation
- Arbitration:
  - rr_last holds the requester granted most recently.
  - If both requesters are valid, grant the one that is not rr_last. Otherwise grant the single valid requester.
- req_ready[g] = grant[g] & (!iss_valid | iss_ready) & (tag_count < TAG_DEPTH). The other req_ready bit is 0.
- The accepting handshake updates:
  - the issue register, loaded with the granted operands and op;
  - iss_valid, set to 1;
  - the tag FIFO, which pushes g;
  - rr_last, set to g.
- If iss_valid & iss_ready occurs with no new acceptance, iss_valid clears.
- Result routing:
  - head = tag FIFO head.
  - out_valid[head] = res_valid & !empty; the other out_valid bit is 0.
  - out_data = res_data.
  - res_ready = out_ready[head] & !empty.
- A result handshake pops the tag FIFO.
- Result while empty: res_ready = 0, both out_valid bits = 0, and err is set until reset.
- Simultaneous push and pop: tag_count stays the same.
- Full FIFO: a push is blocked even if a pop happens in the same cycle. tag_count = TAG_DEPTH is the only full state.
- Pointers are log2(TAG_DEPTH) bits and wrap modulo TAG_DEPTH. tag_count is log2(TAG_DEPTH)+1 bits.

## Timing
- Request-to-issue latency: 1 cycle. iss_valid rises on the edge after the request handshake.
- Throughput: 1 request per cycle while iss_ready = 1 and the FIFO is not full.
- Result-to-output path is combinational, with zero latency.
- The issue payload is held stable while iss_valid & !iss_ready.
- Reset (rst_n = 0 at an edge):
  - iss_valid = 0, err = 0, FIFO empty, tag_count = 0, rr_last = 1 (so requester 0 wins first);
  - iss payload registers = 0;
  - outputs derived from state therefore read: req_ready = 0 while asserted, out_valid = 0, res_ready = 0.
- Reset in mid-operation discards all outstanding tags. Results from requests already inside the unit must be flushed by the unit's own reset.

## Structure
- Shared package (definitions_pack) holds:
  - vec_op_t enum: VOP_ADD, VOP_SUB, VOP_DOT, VOP_CROSS, 2 bits;
  - the requester-ID typedef.
- vector and fixed come from the existing math/definitions packages.
- Sub-module tag_fifo: a 1-bit wide, TAG_DEPTH-deep synchronous FIFO with push, pop, head, empty, full and count.
- The arbiter, issue register and routing logic stay in the top module.

## Test plan
- Single requester: req_valid = 01, op VOP_ADD, a = (1,2,3) -> iss_valid = 1 one cycle later with iss_a = (1,2,3). A result (4,4,4) appears on out_valid = 01.
- Contention: both requesters valid for 4 cycles, iss_ready = 1 -> grants alternate 0,1,0,1. Results are returned in order to ports 0,1,0,1.
- Issue stall: iss_ready = 0 for 3 cycles -> iss payload is held, req_ready = 00, and iss_valid drops after a single iss_ready pulse.
- FIFO full: TAG_DEPTH = 4, 4 issues with no results -> req_ready = 00. One result handshake -> exactly one further acceptance on the next cycle.
- Output backpressure: head tag = 1, res_valid = 1, out_ready = 01 -> res_ready = 0 and the FIFO is held. out_ready = 10 -> pop.
- Error and reset: res_valid with an empty FIFO -> err = 1, out_valid = 00. Setting rst_n = 0 for one edge with 2 tags outstanding -> err = 0 and the FIFO is empty.
